rptr_handler: RTL and testbench



---
 rtl/fifo_pkg.sv | 34 +++
 rtl/gray2bin_conv.sv | 13 +
 rtl/rptr_handler.sv | 66 ++++++
 tb/tb_rptr_handler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width and Gray/binary helpers.
package fifo_pkg;

    localparam int unsigned DEF_PTR_WIDTH = 3;
    localparam int unsigned MAX_W         = 32;

    // Binary to Gray over the low w bits; bits at and above w are cleared.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] g;
        g = b ^ (b >> 1);
        for (int i = 0; i < int'(MAX_W); i++) begin
            if (i >= int'(w)) g[i] = 1'b0;
        end
        return g;
    endfunction

    // Gray to binary: XOR-prefix from the MSB down over the low w bits.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] b;
        logic             acc;
        b   = '0;
        acc = 1'b0;
        for (int i = int'(MAX_W) - 1; i >= 0; i--) begin
            if (i < int'(w)) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared by both FIFO pointer domains.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_c
);

    assign bin_c = WIDTH'(gray2bin(MAX_W'(gray), WIDTH));

endmodule

// File: rtl/rptr_handler.sv
// Read-side pointer/status controller of the dual-clock FIFO: pointers,
// empty/almost-empty, fill level, accept strobe and sticky underflow.
module rptr_handler
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = fifo_pkg::DEF_PTR_WIDTH,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 r_ack,
    output logic                 underflow
);

    localparam int unsigned PW = PTR_WIDTH + 1;

    logic          rd_acc_c;
    logic [PW-1:0] b_rptr_next_c;
    logic [PW-1:0] g_rptr_next_c;
    logic [PW-1:0] b_wptr_sync_c;
    logic [PW-1:0] level_next_c;

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray  (g_wptr_sync),
        .bin_c (b_wptr_sync_c)
    );

    // Next-state terms; empty is the registered flag, so a read is never
    // accepted on the same edge that data first becomes visible.
    always_comb begin
        rd_acc_c      = r_en & ~empty;
        b_rptr_next_c = b_rptr + PW'(rd_acc_c);
        g_rptr_next_c = PW'(bin2gray(MAX_W'(b_rptr_next_c), PW));
        level_next_c  = b_wptr_sync_c - b_rptr_next_c;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            r_ack        <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_rptr_next_c;
            g_rptr       <= g_rptr_next_c;
            empty        <= (g_rptr_next_c == g_wptr_sync);
            almost_empty <= (32'(level_next_c) <= AE_THRESH);
            rd_level     <= level_next_c;
            r_ack        <= rd_acc_c;
            if (r_en && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rptr_handler.sv
// Directed self-checking bench for rptr_handler (PTR_WIDTH=3, AE_THRESH=1).
module tb_rptr_handler;

    logic       rclk;
    logic       rrst;
    logic       r_en;
    logic [3:0] g_wptr_sync;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       r_ack;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    rptr_handler #(
        .PTR_WIDTH (3),
        .AE_THRESH (1)
    ) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .r_en         (r_en),
        .g_wptr_sync  (g_wptr_sync),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .r_ack        (r_ack),
        .underflow    (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] b, input logic [3:0] g,
                             input logic e, input logic ae, input logic [3:0] lvl,
                             input logic ack, input logic uf);
        check({tag, ".b_rptr"},       32'(b_rptr),       32'(b));
        check({tag, ".g_rptr"},       32'(g_rptr),       32'(g));
        check({tag, ".empty"},        32'(empty),        32'(e));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        check({tag, ".rd_level"},     32'(rd_level),     32'(lvl));
        check({tag, ".r_ack"},        32'(r_ack),        32'(ack));
        check({tag, ".underflow"},    32'(underflow),    32'(uf));
    endtask

    // One rclk cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        rrst        = 1'b1;
        r_en        = 1'b0;
        g_wptr_sync = 4'b0000;
        step();
        step();
        check_all("reset", 4'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        rrst = 1'b0;

        // Read while empty: pointers frozen, underflow sticky
        r_en = 1'b1;
        step();
        check_all("uf1", 4'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        step();
        check_all("uf2", 4'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        r_en = 1'b0;

        // Fill three words then drain
        g_wptr_sync = 4'b0010;
        step();
        check_all("fill", 4'd0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        r_en = 1'b1;
        step();
        check_all("drain1", 4'd1, 4'b0001, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1);
        step();
        check_all("drain2", 4'd2, 4'b0011, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        step();
        check_all("drain3", 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        r_en = 1'b0;
        step();
        check_all("idle", 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);

        // Move read pointer to 8, then test wrap with write at 9
        g_wptr_sync = 4'b1100;
        step();
        check_all("to8_fill", 4'd3, 4'b0010, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
        r_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_all("at8", 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        r_en        = 1'b0;
        g_wptr_sync = 4'b1101;
        step();
        check_all("wrap_lvl", 4'd8, 4'b1100, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        r_en = 1'b1;
        step();
        check_all("wrap_rd", 4'b1001, 4'b1101, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        r_en = 1'b0;

        // Read accepted in the same cycle the write pointer advances
        g_wptr_sync = 4'b1111;
        step();
        check_all("simul_pre", 4'd9, 4'b1101, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        r_en        = 1'b1;
        g_wptr_sync = 4'b1110;
        step();
        check_all("simul", 4'd10, 4'b1111, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);

        // Reset with a pending accepted read
        rrst = 1'b1;
        step();
        check_all("midrst", 4'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        rrst = 1'b0;
        r_en = 1'b0;

        // Full-depth level and drain of eight words
        g_wptr_sync = 4'b1100;
        step();
        check_all("full", 4'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("full_drain.b_rptr", 32'(b_rptr), i);
            check("full_drain.g_rptr", 32'(g_rptr), 32'(gray(4'(i))));
            check("full_drain.empty",  32'(empty),  (i == 8) ? 32'd1 : 32'd0);
            check("full_drain.level",  32'(rd_level), 32'(8 - i));
        end
        r_en = 1'b0;
        step();
        check_all("full_end", 4'd8, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
